// File: rtl/seq_bypass_subtractor_if.sv
// Handshake and operand/result bundle for seq_bypass_subtractor.
// byp_cnt exists only when BYPASS_STATS_EN is defined.
interface seq_bypass_subtractor_if #(
  parameter int N = 32
);
`ifdef BYPASS_STATS_EN
  localparam int CW = $clog2(N / 8) + 1;
`endif

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         in_ready;
  logic         busy;
  logic         valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         overflow;
`ifdef BYPASS_STATS_EN
  logic [CW-1:0] byp_cnt;
`endif

  modport master (
    output start, a, b, bin, out_ready,
    input  in_ready, busy, valid, diff, borrow_out, overflow
`ifdef BYPASS_STATS_EN
    , input byp_cnt
`endif
  );

  modport slave (
    input  start, a, b, bin, out_ready,
    output in_ready, busy, valid, diff, borrow_out, overflow
`ifdef BYPASS_STATS_EN
    , output byp_cnt
`endif
  );
endinterface

// File: rtl/seq_bypass_subtractor.sv
// Sequential N-bit subtractor, one 8-bit carry-bypass block per cycle (a + ~b + ~bin).
// Optional bypassed-block counter on byp_cnt when BYPASS_STATS_EN is defined.
module seq_bypass_subtractor #(
  parameter int N   = 32,
  parameter int BLK = 8
) (
  input logic                   clk,
  input logic                   rst,
  seq_bypass_subtractor_if.slave bus
);
  localparam int NB = N / BLK;
  localparam int KW = $clog2(NB) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Returns {carry_out, carry_into_msb, sum}; carry_out takes the bypass path when all bits propagate.
  function automatic logic [BLK+1:0] blk_step(input logic [BLK-1:0] x,
                                              input logic [BLK-1:0] y_n,
                                              input logic           cin);
    logic [BLK:0]   rip;
    logic [BLK-1:0] p;
    logic           c_msb;
    logic           cout;
    rip   = {1'b0, x} + {1'b0, y_n} + {{BLK{1'b0}}, cin};
    p     = x ^ y_n;
    c_msb = p[BLK-1] ^ rip[BLK-1];
    cout  = (&p) ? cin : rip[BLK];
    return {cout, c_msb, rip[BLK-1:0]};
  endfunction

  state_t         state;
  logic [N-1:0]   work_p0;
  logic [N-1:0]   subt_p0;
  logic           carry_p0;
  logic [KW-1:0]  k_p0;
  logic [N-1:0]   diff_q;
  logic           borrow_q;
  logic           ovf_q;
  logic           in_ready_q;
  logic           busy_q;
  logic           valid_q;
`ifdef BYPASS_STATS_EN
  logic [KW-1:0]  byp_q;
`endif

  logic [BLK+1:0] step;
  logic [BLK-1:0] blk_sum;
  logic           blk_cout;
  logic           blk_cmsb;
  logic           blk_byp;
  logic           last_blk;

  always_comb begin
    step     = blk_step(work_p0[BLK-1:0], ~subt_p0[BLK-1:0], carry_p0);
    blk_sum  = step[BLK-1:0];
    blk_cmsb = step[BLK];
    blk_cout = step[BLK+1];
    blk_byp  = &(work_p0[BLK-1:0] ^ ~subt_p0[BLK-1:0]);
    last_blk = (k_p0 == KW'(NB - 1));
  end

  // Stage p0: work_p0 shifts operand blocks out at the bottom and sum blocks in at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      carry_p0   <= 1'b0;
      k_p0       <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef BYPASS_STATS_EN
      byp_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work_p0    <= bus.a;
            subt_p0    <= bus.b;
            carry_p0   <= ~bus.bin;
            k_p0       <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef BYPASS_STATS_EN
            byp_q      <= '0;
`endif
          end
        end
        RUN: begin
          work_p0  <= {blk_sum, work_p0[N-1:BLK]};
          subt_p0  <= subt_p0 >> BLK;
          carry_p0 <= blk_cout;
          k_p0     <= k_p0 + 1'b1;
`ifdef BYPASS_STATS_EN
          if (blk_byp) byp_q <= byp_q + 1'b1;
`endif
          if (last_blk) begin
            diff_q   <= {blk_sum, work_p0[N-1:BLK]};
            borrow_q <= ~blk_cout;
            ovf_q    <= blk_cmsb ^ blk_cout;
            state    <= DONE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          valid_q    <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifndef BYPASS_STATS_EN
  logic unused_byp;
  assign unused_byp = blk_byp;
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;
`ifdef BYPASS_STATS_EN
  assign bus.byp_cnt    = byp_q;
`endif
endmodule

// File: tb/tb_seq_bypass_subtractor.sv
// Directed + random bench for seq_bypass_subtractor against an arithmetic reference model.
module tb_seq_bypass_subtractor;
  localparam int N  = 32;
  localparam int NB = N / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_bypass_subtractor_if #(.N(N)) bus ();
  seq_bypass_subtractor #(.N(N), .BLK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       output logic [N-1:0] d, output logic bo, output logic ov, output int bc);
    longint ua, ub, sa, sb, sres, lim;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sres = sa - sb - longint'(bin);
    lim  = longint'(1) <<< (N - 1);
    d    = N'(ua - ub - longint'(bin));
    bo   = (ua < ub + longint'(bin));
    ov   = (sres < -lim) || (sres > lim - 1);
    bc   = 0;
    for (int i = 0; i < NB; i++)
      if (a[8*i +: 8] == b[8*i +: 8]) bc++;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                        input int hold, input logic start_at_release);
    logic [N-1:0] ed;
    logic         eb, eo;
    int           ebc, cyc;
    model(a, b, bin, ed, eb, eo, ebc);
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom_range(0, 1));
    check("busy_run", bus.busy, 1);
    cyc = 0;
    while (!bus.valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'($urandom_range(0, 1));
      bus.a = $urandom; bus.b = $urandom;
    end
    bus.start = 1'b0;
    check("latency", 64'(cyc), 64'(NB));
    check("diff", bus.diff, ed);
    check("borrow_out", bus.borrow_out, eb);
    check("overflow", bus.overflow, eo);
`ifdef BYPASS_STATS_EN
    check("byp_cnt", bus.byp_cnt, 64'(ebc));
`endif
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      @(negedge clk);
      check("hold_valid", bus.valid, 1);
      check("hold_diff", bus.diff, ed);
      check("hold_flags", {bus.borrow_out, bus.overflow}, {eb, eo});
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.start = start_at_release;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    check("release_valid", bus.valid, 0);
    check("release_idle", {bus.in_ready, bus.busy}, 2'b10);
    check("idle_diff_held", bus.diff, ed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    rst = 1'b1;
    bus.start = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_ctrl", {bus.valid, bus.busy}, 2'b00);
    check("rst_diff", bus.diff, 0);
    check("rst_flags", {bus.borrow_out, bus.overflow}, 2'b00);
`ifdef BYPASS_STATS_EN
    check("rst_byp", bus.byp_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_op(32'h00FF_0000, 32'h00FF_0000, 1'b1, 0, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 3, 1'b1);

    // Abort in the second RUN cycle.
    bus.a = 32'hFFFF_0000; bus.b = 32'h0000_FFFF; bus.bin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0; bus.out_ready = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_ctrl", {bus.valid, bus.busy}, 2'b00);
    check("abort_diff", bus.diff, 0);
    check("abort_flags", {bus.borrow_out, bus.overflow}, 2'b00);
`ifdef BYPASS_STATS_EN
    check("abort_byp", bus.byp_cnt, 0);
`endif
    repeat (NB + 1) @(negedge clk);
    check("abort_no_valid", bus.valid, 0);
    run_op(32'd10, 32'd4, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      for (int j = 0; j < NB; j++)
        if ($urandom_range(0, 2) == 0) rb[8*j +: 8] = ra[8*j +: 8];
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_bypass_subtractor.md
SEQ_BYPASS_SUBTRACTOR -- requirements
Module: seq_bypass_subtractor

Interface
REQ-001 Parameter: N, 32, operand width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter: BLK, 8, block width in bits processed per cycle; fixed at 8.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to accept a, b, bin.
REQ-006 a  input  N  minuend.
REQ-007 b  input  N  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 in_ready  output  1  high only in IDLE; start accepted when start & in_ready.
REQ-010 busy  output  1  high in RUN.
REQ-011 valid  output  1  result valid; high only in DONE.
REQ-012 out_ready  input  1  consumer accepts result when valid & out_ready.
REQ-013 diff  output  N  a - b - bin, modulo 2^N.
REQ-014 borrow_out  output  1  1 when unsigned a < b + bin.
REQ-015 overflow  output  1  signed overflow of a - b - bin.
REQ-016 byp_cnt  output  clog2(N/8)+1  blocks bypassed in last operation (present only with BYPASS_STATS_EN).

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE -> RUN on start & in_ready; a, b, bin captured at that edge; block index k cleared to 0.
REQ-019 Subtraction SHALL be formed as a + ~b + carry, with internal carry-in = ~bin.
REQ-020 RUN: one 8-bit block per cycle, block k = bits [8k+7:8k], k = 0 .. N/8-1, lowest block first.
REQ-021 Per block: propagate p = a_blk ^ ~b_blk; when &p = 1 the block carry-out SHALL equal the block carry-in (bypass path); otherwise it SHALL be the ripple carry-out.
REQ-022 Bypass and ripple SHALL give identical results; bypass is a structural requirement, not a functional one.
REQ-023 RUN -> DONE after block N/8-1 is processed; valid SHALL rise exactly N/8 cycles after the accepting edge.
REQ-024 borrow_out = ~(final carry); overflow = carry into MSB XOR carry out of MSB.
REQ-025 DONE: diff, borrow_out, overflow held stable while valid & ~out_ready.
REQ-026 DONE -> IDLE on out_ready; results remain held in IDLE until the next accepting edge.
REQ-027 start outside IDLE SHALL be ignored with no side effects.
REQ-028 In DONE, start & out_ready together: result completes and start is ignored; a new op needs start in IDLE.
REQ-029 Operand inputs SHALL be ignored except at the accepting edge.

Reset
REQ-030 rst high at an edge: state IDLE; diff, borrow_out, overflow, valid, busy, byp_cnt = 0; in_ready = 1 in the following cycle.
REQ-031 Reset in RUN or DONE SHALL abort the operation; no partial result is ever presented with valid high.
REQ-032 rst SHALL take priority over start and out_ready at the same edge.

Configuration
REQ-033 Macro BYPASS_STATS_EN defined: byp_cnt port present; cleared at accepting edge, incremented once per block with &p = 1, final value held from DONE until next accept.
REQ-034 Macro BYPASS_STATS_EN undefined: no byp_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-035 a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, borrow_out=0, overflow=0, valid 4 cycles after accept.
REQ-036 a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, borrow_out=1, overflow=0.
REQ-037 a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, borrow_out=0, overflow=1.
REQ-038 a=0x12345678, b=0x12345678, bin=0 (all blocks bypass) -> diff=0, borrow_out=0; with BYPASS_STATS_EN byp_cnt=4.
REQ-039 Hold out_ready low 3 cycles in DONE, pulse start each cycle -> valid and outputs stable, start ignored, IDLE one cycle after out_ready.
REQ-040 rst on 2nd RUN cycle -> next cycle all outputs 0, in_ready=1; following op a=10, b=4 -> diff=6.
